// File: rtl/svm_seq_pkg.sv
// Shared types and helpers for the sequential one-vs-rest SVM classifier.
package svm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Add two wide signed values and clamp to the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int width);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    s  = a + b;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (s > hi) begin
      r = hi;
    end else if (s < lo) begin
      r = lo;
    end else begin
      r = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/svm_mac_lanes.sv
// Combinational LANES-wide signed multiply/sum for one step of one hyperplane.
module svm_mac_lanes #(
  parameter int N_FEATURES = 11,
  parameter int LANES      = 1,
  parameter int IN_W       = 4,
  parameter int W_W        = 8,
  parameter int STEP_W     = 4,
  parameter int SUM_W      = 14
) (
  input  logic [IN_W*N_FEATURES-1:0] x_vec,
  input  logic [W_W*N_FEATURES-1:0]  w_vec,
  input  logic [STEP_W-1:0]          step,
  output logic signed [SUM_W-1:0]    sum
);

  localparam int PROD_W = W_W + IN_W + 1;

  logic [IN_W-1:0]          x_l;
  logic signed [W_W-1:0]    w_l;
  logic signed [PROD_W-1:0] prod_l;
  int                       idx;

  // Lanes that run past the last feature in the final step contribute nothing.
  always_comb begin
    sum    = '0;
    x_l    = '0;
    w_l    = '0;
    prod_l = '0;
    idx    = 0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(step) * LANES + l;
      if (idx < N_FEATURES) begin
        x_l    = x_vec[idx*IN_W +: IN_W];
        w_l    = w_vec[idx*W_W +: W_W];
        prod_l = w_l * $signed({1'b0, x_l});
        sum    = sum + SUM_W'(prod_l);
      end
    end
  end

endmodule

// File: rtl/seq_multiclass_svm.sv
// Sequential one-vs-rest linear SVM with argmax (binary sign mode when N_CLASSES=1).
// Define SVM_SATURATE_EN to saturate accumulator updates instead of wrapping.
module seq_multiclass_svm
  import svm_seq_pkg::*;
#(
  parameter int N_FEATURES = 11,
  parameter int N_CLASSES  = 6,
  parameter int LANES      = 1,
  parameter int IN_W       = 4,
  parameter int W_W        = 8,
  parameter int B_W        = 8,
  parameter int BIAS_SHIFT = 4,
  parameter int ACC_W      = 16,
  parameter int CLS_W      = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [IN_W*N_FEATURES-1:0]        inputs,
  input  logic [W_W*N_FEATURES*N_CLASSES-1:0] weights,
  input  logic [B_W*N_CLASSES-1:0]          biases,
  output logic                              busy,
  output logic                              valid,
  output logic [CLS_W-1:0]                  class_o,
  output logic [ACC_W-1:0]                  score_o
);

  localparam int STEPS  = ceil_div(N_FEATURES, LANES);
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PROD_W = W_W + IN_W + 1;
  localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;
  localparam int ROW_W  = W_W * N_FEATURES;

  state_t                    state_q, state_d;
  logic [IN_W*N_FEATURES-1:0] x_q, x_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CLS_W-1:0]          cls_q, cls_d;
  logic [STEP_W-1:0]         step_q, step_d;
  logic signed [ACC_W-1:0]   best_q, best_d;
  logic [CLS_W-1:0]          best_cls_q, best_cls_d;
  logic                      valid_q, valid_d;
  logic [CLS_W-1:0]          class_q, class_d;
  logic signed [ACC_W-1:0]   score_q, score_d;

  logic [ROW_W-1:0]          w_row;
  logic signed [B_W-1:0]     bias_c;
  logic signed [SUM_W-1:0]   mac_sum;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   score_c;
  logic                      last_step;
  logic                      last_class;

  svm_mac_lanes #(
    .N_FEATURES (N_FEATURES),
    .LANES      (LANES),
    .IN_W       (IN_W),
    .W_W        (W_W),
    .STEP_W     (STEP_W),
    .SUM_W      (SUM_W)
  ) u_mac (
    .x_vec (x_q),
    .w_vec (w_row),
    .step  (step_q),
    .sum   (mac_sum)
  );

  // Datapath: this cycle's partial sum, plus the shifted bias on a class's last step.
  always_comb begin
    w_row  = weights[cls_q*ROW_W +: ROW_W];
    bias_c = biases[cls_q*B_W +: B_W];
`ifdef SVM_SATURATE_EN
    acc_next = ACC_W'(sat_add(64'(acc_q), 64'(mac_sum), ACC_W));
    score_c  = ACC_W'(sat_add(64'(acc_next), 64'(bias_c) <<< BIAS_SHIFT, ACC_W));
`else
    acc_next = acc_q + ACC_W'(mac_sum);
    score_c  = acc_next + (ACC_W'(bias_c) <<< BIAS_SHIFT);
`endif
    last_step  = (step_q == STEP_W'(STEPS - 1));
    last_class = (cls_q == CLS_W'(N_CLASSES - 1));
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    acc_d      = acc_q;
    cls_d      = cls_q;
    step_d     = step_q;
    best_d     = best_q;
    best_cls_d = best_cls_q;
    valid_d    = valid_q;
    class_d    = class_q;
    score_d    = score_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ACCUM;
          x_d     = inputs;
          acc_d   = '0;
          cls_d   = '0;
          step_d  = '0;
          valid_d = 1'b0;
        end
      end
      ACCUM: begin
        if (last_step) begin
          acc_d  = '0;
          step_d = '0;
          // Strict compare so that ties keep the lower class index.
          if (cls_q == '0 || score_c > best_q) begin
            best_d     = score_c;
            best_cls_d = cls_q;
          end
          if (last_class) begin
            state_d = DONE;
            valid_d = 1'b1;
            cls_d   = '0;
            score_d = best_d;
            class_d = (N_CLASSES == 1) ? CLS_W'(score_c[ACC_W-1]) : best_cls_d;
          end else begin
            cls_d = cls_q + CLS_W'(1);
          end
        end else begin
          acc_d  = acc_next;
          step_d = step_q + STEP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      acc_q      <= '0;
      cls_q      <= '0;
      step_q     <= '0;
      best_q     <= '0;
      best_cls_q <= '0;
      valid_q    <= 1'b0;
      class_q    <= '0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      acc_q      <= acc_d;
      cls_q      <= cls_d;
      step_q     <= step_d;
      best_q     <= best_d;
      best_cls_q <= best_cls_d;
      valid_q    <= valid_d;
      class_q    <= class_d;
      score_q    <= score_d;
    end
  end

  assign busy    = (state_q == ACCUM);
  assign valid   = valid_q;
  assign class_o = class_q;
  assign score_o = score_q;

endmodule

// File: doc/seq_multiclass_svm.md
Name: seq_multiclass_svm

Overview:
Sequential one-vs-rest multiclass linear SVM for printed-electronics classifiers.
- Evaluates N_CLASSES hyperplanes over N_FEATURES inputs, LANES multiply-accumulates per cycle.
- Selects the class with the maximum score.
- Generalises the single-class serial sign classifier with a start/valid handshake, multi-lane datapath, argmax and a binary sign mode.
- Sits between the input sampling front-end and the class output register bank.

Parameters:
N_FEATURES, 11, number of input features
N_CLASSES, 6, number of hyperplanes; 1 selects binary sign mode
LANES, 1, features processed per cycle (1..N_FEATURES)
IN_W, 4, unsigned input width
W_W, 8, signed weight width
B_W, 8, signed bias width
BIAS_SHIFT, 4, left shift applied to bias before accumulation
ACC_W, 16, signed accumulator/score width
CLS_W, max(1,$clog2(N_CLASSES)), class index width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request classification; sampled only when not busy
inputs  in  IN_W*N_FEATURES  feature vector, feature f at [f*IN_W +: IN_W]
weights  in  W_W*N_FEATURES*N_CLASSES  weight (c,f) at [(c*N_FEATURES+f)*W_W +: W_W]
biases  in  B_W*N_CLASSES  bias c at [c*B_W +: B_W]
busy  out  1  computation in progress
valid  out  1  result available; held until next accepted start
class_o  out  CLS_W  winning class index (sign bit in binary mode)
score_o  out  ACC_W  winning score (raw score in binary mode)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: FSM=IDLE, busy=0, valid=0, class_o=0, score_o=0, accumulator=0, counters=0.
- STEPS = ceil(N_FEATURES/LANES).
- FSM: IDLE -> ACCUM on start; ACCUM -> DONE after final step of final class; DONE -> ACCUM on start.
- Accepting start (IDLE or DONE):
  - latch inputs into a register; weights and biases are static and not latched
  - clear accumulator, class counter and step counter
  - valid=0, busy=1
- start while busy=1 is ignored.
- Each ACCUM cycle:
  - adds sum over lanes of $signed(w) * $signed({1'b0,x}) to the accumulator
  - lanes with feature index >= N_FEATURES contribute 0
- Last step of a class:
  - also adds sign-extended bias<<BIAS_SHIFT
  - the resulting score is compared in the same cycle, not registered first
  - class 0 always loads best; later class loads only if score > best (strict), so ties keep the lower index
  - accumulator clears and the class counter increments
- Latency: valid rises N_CLASSES*STEPS+1 rising edges after the start edge, counting the start edge as edge 1. busy falls on the same edge.
- Outputs on DONE: class_o/score_o are updated when DONE is entered and held stable while valid=1.
- Binary mode (N_CLASSES=1): class_o = sign bit of score; score_o = score.
- Arithmetic: products are W_W+IN_W+1 bits, sign-extended to ACC_W. Default overflow is two's-complement wrap.
- Reset mid-operation returns to reset values immediately. No partial result is visible.

Optional Feature:
SVM_SATURATE_EN
- Defined: every accumulator update saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Undefined: wraps modulo 2^ACC_W.
- Argmax and sign rules are unchanged either way.

Decomposition:
- Package svm_seq_pkg:
  - state enum typedef (IDLE, ACCUM, DONE)
  - ceil_div function for STEPS
  - saturating-add function
- Sub-module svm_mac_lanes: combinational LANES-wide signed product sum with out-of-range lane masking, instantiated once.

Test Plan:
Config for all tests: N_FEATURES=3, N_CLASSES=3, LANES=2, ACC_W=16, BIAS_SHIFT=4, so STEPS=2 and latency is 7.
- Basic argmax:
  - stimulus: x=[1,2,3]; w0=[1,1,1], w1=[2,0,0], w2=[0,0,5]; biases 0; pulse start
  - response: valid high exactly 7 edges later, class_o=2, score_o=15, busy low
- Tie-break:
  - stimulus: w0=w1=[1,1,1], w2=[0,0,0], x=[1,2,3]
  - response: class_o=0, score_o=6
- Bias only:
  - stimulus: all weights 0, biases [-1,2,1]
  - response: scores -16/32/16, class_o=1, score_o=32
- Binary mode:
  - stimulus: N_CLASSES=1, x=[15,15,15], w=[-128,-128,-128], bias 0
  - response: score_o=-5760, class_o=1
- Overflow:
  - stimulus: ACC_W=8, N_CLASSES=1, x=[15,15,15], w=[127,127,127]
  - response: score_o=83 without SVM_SATURATE_EN; score_o=127 with it
- Control:
  - stimulus: start re-pulsed during busy
  - response: ignored, result unchanged
  - stimulus: rst_n low mid-ACCUM, then a fresh start
  - response: all outputs 0 immediately; fresh start gives the correct result with latency 7
